// File: rtl/counter_min_hour.sv
// rtl/counter_min_hour.sv - minute/hour counter stage with parallel load and rollover carries
module counter_min_hour #(
    parameter int MIN_W    = 6,
    parameter int HOUR_W   = 5,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic              clock,
    input  logic              reset_min,
    input  logic              enable_min,
    input  logic [MIN_W-1:0]  data_min,
    input  logic              load_min,
    input  logic [HOUR_W-1:0] data_hour,
    input  logic              load_hour,
    output logic [MIN_W-1:0]  count_min,
    output logic [HOUR_W-1:0] count_hour,
    output logic              carry_min,
    output logic              carry_day,
    output logic              load_err
);

    localparam logic [MIN_W-1:0]  MIN_TERM  = MIN_W'(MIN_MAX);
    localparam logic [HOUR_W-1:0] HOUR_TERM = HOUR_W'(HOUR_MAX);
    localparam logic [MIN_W-1:0]  MIN_ONE   = MIN_W'(1);
    localparam logic [HOUR_W-1:0] HOUR_ONE  = HOUR_W'(1);

    logic min_at_max;
    logic hour_at_max;
    logic min_load_ok;
    logic hour_load_ok;
    logic load_reject;

    assign min_at_max   = (count_min == MIN_TERM);
    assign hour_at_max  = (count_hour == HOUR_TERM);
    assign min_load_ok  = (data_min <= MIN_TERM);
    assign hour_load_ok = (data_hour <= HOUR_TERM);

    // A rejected load of either field raises the same single error pulse.
    assign load_reject  = (load_min & ~min_load_ok) | (load_hour & ~hour_load_ok);

    // The carries depend only on registered counts and control strobes, never on data_*.
    assign carry_min = enable_min & min_at_max & ~load_min & ~reset_min;
    assign carry_day = carry_min & hour_at_max & ~load_hour;

    always_ff @(posedge clock) begin
        if (reset_min) begin
            count_min <= '0;
        end else if (load_min) begin
            if (min_load_ok) begin
                count_min <= data_min;
            end
        end else if (enable_min) begin
            count_min <= min_at_max ? '0 : count_min + MIN_ONE;
        end
    end

    // An hour load (valid or not) pre-empts the minute carry for that edge.
    always_ff @(posedge clock) begin
        if (reset_min) begin
            count_hour <= '0;
        end else if (load_hour) begin
            if (hour_load_ok) begin
                count_hour <= data_hour;
            end
        end else if (carry_min) begin
            count_hour <= hour_at_max ? '0 : count_hour + HOUR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_min) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load_reject;
        end
    end

endmodule

// File: tb/tb_counter_min_hour.sv
// tb/tb_counter_min_hour.sv - table-driven and sequence checks for counter_min_hour
module tb_counter_min_hour;

    logic       clock = 1'b0;
    logic       reset_min = 1'b0;
    logic       enable_min = 1'b0;
    logic [5:0] data_min = '0;
    logic       load_min = 1'b0;
    logic [4:0] data_hour = '0;
    logic       load_hour = 1'b0;
    logic [5:0] count_min;
    logic [4:0] count_hour;
    logic       carry_min;
    logic       carry_day;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;

    counter_min_hour dut (
        .clock      (clock),
        .reset_min  (reset_min),
        .enable_min (enable_min),
        .data_min   (data_min),
        .load_min   (load_min),
        .data_hour  (data_hour),
        .load_hour  (load_hour),
        .count_min  (count_min),
        .count_hour (count_hour),
        .carry_min  (carry_min),
        .carry_day  (carry_day),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       lmin;
        logic [5:0] dmin;
        logic       lhour;
        logic [4:0] dhour;
        logic       exp_cmin;
        logic       exp_cday;
        logic [5:0] exp_min;
        logic [4:0] exp_hour;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic en,
                                input logic lmin, input int dmin,
                                input logic lhour, input int dhour,
                                input logic ecm, input logic ecd,
                                input int emin, input int ehour, input logic eerr);
        vec_t v;
        v.rst = rst; v.en = en;
        v.lmin = lmin; v.dmin = 6'(dmin);
        v.lhour = lhour; v.dhour = 5'(dhour);
        v.exp_cmin = ecm; v.exp_cday = ecd;
        v.exp_min = 6'(emin); v.exp_hour = 5'(ehour); v.exp_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic lmin, input logic [5:0] dmin,
                         input logic lhour, input logic [4:0] dhour);
        reset_min = rst; enable_min = en;
        load_min = lmin; data_min = dmin;
        load_hour = lhour; data_hour = dhour;
    endtask

    int carries;

    initial begin
        //            rst en lm dm  lh dh  cmin cday min hr err
        vecs.push_back(mk(1, 1, 0,  0, 0,  0, 0, 0,  0,  0, 0)); // reset beats enable
        vecs.push_back(mk(1, 0, 0,  0, 0,  0, 0, 0,  0,  0, 0));
        vecs.push_back(mk(0, 0, 1, 58, 1, 23, 0, 0, 58, 23, 0));
        vecs.push_back(mk(0, 1, 0,  0, 0,  0, 0, 0, 59, 23, 0));
        vecs.push_back(mk(0, 1, 0,  0, 0,  0, 1, 1,  0,  0, 0)); // day rollover
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,  0,  0, 0));
        vecs.push_back(mk(0, 1, 1, 59, 0,  0, 0, 0, 59,  0, 0)); // load beats enable
        vecs.push_back(mk(0, 1, 1, 59, 0,  0, 0, 0, 59,  0, 0)); // at 59: load suppresses carry
        vecs.push_back(mk(0, 0, 0,  0, 1, 10, 0, 0, 59, 10, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1,  5, 1, 0,  0,  5, 0)); // hour load beats carry
        vecs.push_back(mk(0, 0, 1, 60, 0,  0, 0, 0,  0,  5, 1)); // invalid minute
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,  0,  5, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1, 24, 0, 0,  0,  5, 1)); // invalid hour
        vecs.push_back(mk(0, 0, 0,  0, 0,  0, 0, 0,  0,  5, 0));
        vecs.push_back(mk(0, 0, 1, 63, 1, 31, 0, 0,  0,  5, 1)); // both invalid
        vecs.push_back(mk(0, 0, 1, 30, 1, 12, 0, 0, 30, 12, 0)); // both valid
        vecs.push_back(mk(0, 0, 1, 59, 1, 23, 0, 0, 59, 23, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1, 23, 1, 0,  0, 23, 0)); // hour load at 23 kills carry_day
        vecs.push_back(mk(0, 0, 1, 59, 0,  0, 0, 0, 59, 23, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1, 24, 1, 0,  0, 23, 1)); // invalid hour load still blocks carry
        vecs.push_back(mk(0, 0, 1, 59, 1, 23, 0, 0, 59, 23, 0));
        vecs.push_back(mk(1, 1, 0,  0, 0,  0, 0, 0,  0,  0, 0)); // reset in carry cycle
        vecs.push_back(mk(0, 1, 0,  0, 0,  0, 0, 0,  1,  0, 0)); // held enable counts every cycle
        vecs.push_back(mk(0, 1, 0,  0, 0,  0, 0, 0,  2,  0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 0,  0, 0, 0,  3,  0, 0));

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].lmin, vecs[i].dmin, vecs[i].lhour, vecs[i].dhour);
            #1;
            check($sformatf("v%0d carry_min", i), carry_min, vecs[i].exp_cmin);
            check($sformatf("v%0d carry_day", i), carry_day, vecs[i].exp_cday);
            @(posedge clock);
            #1;
            check($sformatf("v%0d count_min", i), count_min, vecs[i].exp_min);
            check($sformatf("v%0d count_hour", i), count_hour, vecs[i].exp_hour);
            check($sformatf("v%0d load_err", i), load_err, vecs[i].exp_err);
        end

        // Full hour of spaced single-cycle minute pulses from reset.
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        check("seq reset count_min", count_min, 0);
        check("seq reset count_hour", count_hour, 0);
        check("seq reset load_err", load_err, 0);
        carries = 0;
        for (int p = 1; p <= 60; p++) begin
            enable_min = 1'b1;
            #1;
            if (carry_min) carries++;
            check($sformatf("seq pulse%0d carry_min", p), carry_min, (p == 60) ? 1 : 0);
            @(posedge clock);
            #1;
            enable_min = 1'b0;
            check($sformatf("seq pulse%0d count_min", p), count_min, p % 60);
            for (int k = 0; k < 3; k++) begin
                #1;
                if (carry_min) carries++;
                @(posedge clock);
                #1;
            end
        end
        check("seq carry_min count", carries, 1);
        check("seq count_hour", count_hour, 1);
        check("seq carry_day", carry_day, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
